ddfs_mc: RTL
============

# ddfs_mc

Parametrised multi-channel direct digital frequency synthesiser, the successor to the single-channel 23-bit `ddfs`. It provides NCH independent phase accumulators, each with its own frequency control word, phase offset and waveform mode (sine, square, sawtooth, triangle). Configuration is written into per-channel shadow registers and applied to all channels in one coherent commit. Outputs drive the DAC/mixer stage as offset-binary samples.

## Interface
- `NCH`, 2: number of channels.
- `ACC_W`, 23: phase accumulator, FCW and phase-offset width.
- `OUT_W`, 8: sample width (offset binary).
- `LUT_AW`, 8: phase bits used for sine lookup. Requires LUT_AW ≥ 3, OUT_W ≤ ACC_W-1, LUT_AW ≤ ACC_W.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_we`  in  1  shadow write strobe.
- `cfg_ch`  in  $clog2(NCH) (min 1)  target channel; values ≥ NCH are ignored.
- `cfg_fcw`  in  ACC_W  frequency control word.
- `cfg_poff`  in  ACC_W  phase offset.
- `cfg_mode`  in  2  0 sine, 1 square, 2 saw, 3 triangle.
- `cfg_commit`  in  1  copy all shadows to active registers.
- `sync`  in  1  clear all accumulators.
- `enable`  in  1  accumulators advance while high.
- `outp`  out  NCH*OUT_W  samples; channel c is at bits [c*OUT_W +: OUT_W].
- `wrap`  out  NCH  per-channel phase-wrap flag, aligned with `outp`.

## Operation
- Per channel: shadow {fcw, poff, mode} and active {fcw, poff, mode}, plus accumulator `acc`.
- `cfg_we` writes all three shadow fields of `cfg_ch`.
- `cfg_commit` loads every active set from its shadow on the same edge. A `cfg_we` in the commit cycle is included (write-through).
- `acc` behaviour per edge:
  - `sync`=1: acc ← 0. Takes priority over `enable`.
  - else `enable`=1: acc ← acc + active fcw, mod 2^ACC_W. The carry-out sets the pending wrap bit.
  - else acc holds. The pipeline keeps running, so `outp` repeats the held phase.
- Phase p = acc + poff, mod 2^ACC_W. t = p[ACC_W-1 -: OUT_W]. MID = 2^(OUT_W-1).
- Waveform by mode:
  - square: p MSB = 0 → 2^OUT_W-1, else 0.
  - saw: t.
  - triangle: r = p[ACC_W-2 -: OUT_W]. Output is r when MSB = 0, else ~r.
  - sine: k = p[ACC_W-1 -: LUT_AW], N = 2^LUT_AW, m = k mod N/4. Q(j) = round((MID-1)·sin(2πj/N)), j = 0..N/4. Quadrants 0..3 give MID+Q(m), MID+Q(N/4-m), MID-Q(m), MID-Q(N/4-m). For quadrants 1 and 3, m = 0 uses Q(N/4).
- Reset (asynchronous): all shadows and actives = 0 with mode sine; acc = 0; pipeline registers cleared; every `outp` lane = MID; `wrap` = 0. Reset mid-operation aborts everything immediately; there is no partial-commit state.

## Timing
- Two-stage pipeline after `acc`:
  - S1 registers p, mode and the wrap bit.
  - S2 registers the waveform value into `outp` and `wrap`.
- Sample latency: acc holds A on cycle n → `outp` shows f(A+poff) on cycle n+2.
- Commit on edge e: the new fcw is first added at edge e+1. The new poff/mode are seen by S1 at edge e+1, so they appear on `outp` after edge e+2.
- `wrap[c]` is high for one cycle, on the sample whose accumulator update overflowed. A sync-to-zero is not a wrap.
- Same-cycle `sync` + `cfg_commit`: acc = 0, then it advances by the new fcw.
- fcw = 0: output is static; `wrap` never asserts.

## Structure
- Package `ddfs_pkg`: mode enum (SINE, SQUARE, SAW, TRI) and the MID/width helper functions.
- Sub-module `ddfs_sine_lut`: quarter-wave ROM with N/4+1 entries, generated at elaboration from OUT_W/LUT_AW. It holds Q and applies quadrant mirroring and sign, with a registered output forming S2.
- Top level: generate loop over channels for the shadow/active/accumulator/S1 logic.

## Test plan
- Reset, then commit with all defaults → every lane = 128, `wrap` = 0 (OUT_W=8).
- ch0: fcw = 2^20, saw, commit, `enable`=1 → `outp[7:0]` = 0,32,64,…,224, repeating with period 8. `wrap` pulses once per period, coincident with 0.
- ch0: sine, fcw = 2^20 → 128, 218, 255, 218, 128, 38, 1, 38 repeating. Same with poff = 2^21 → sequence starts at 255.
- ch1: fcw = 2^21 square; ch0: fcw = 2^20 tri → ch1 alternates 255,255,0,0; ch0 follows 0,64,128,192,255,191,127,63.
- Shadow write of a new fcw without commit → output frequency unchanged. Commit → period changes exactly one edge after commit. Same-cycle `cfg_we`+`cfg_commit` takes effect.
- `sync` mid-stream plus `enable` low → accumulators frozen at 0, `outp` constant at f(poff). `rst_n` low mid-run → outputs = 128 asynchronously.

Source files
------------

// File: rtl/ddfs_pkg.sv
// Shared types and elaboration helpers for the multi-channel DDFS.
package ddfs_pkg;

  typedef enum logic [1:0] {
    SINE   = 2'd0,
    SQUARE = 2'd1,
    SAW    = 2'd2,
    TRI    = 2'd3
  } mode_t;

  function automatic int mid_val(int out_w);
    return 1 << (out_w - 1);
  endfunction

  // Channel-select width, never narrower than one bit.
  function automatic int ch_width(int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/ddfs_sine_lut.sv
// Quarter-wave sine ROM with quadrant mirroring/sign; its output register is
// the second pipeline stage and also carries the non-sine waveforms.
module ddfs_sine_lut
  import ddfs_pkg::*;
#(
  parameter int OUT_W  = 8,
  parameter int LUT_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LUT_AW-1:0] phase,
  input  logic [OUT_W-1:0]  alt,
  input  logic              sel_alt,
  output logic [OUT_W-1:0]  sample
);

  localparam int QN = 1 << (LUT_AW - 2);
  localparam logic [OUT_W-1:0] MID = OUT_W'(mid_val(OUT_W));

  // round((MID-1) * sin(pi/2 * j/QN)) via a Taylor series evaluated at elaboration.
  function automatic int q_of(int j);
    real x, term, s;
    x    = 3.14159265358979323846 * real'(j) / real'(2 * QN);
    term = x;
    s    = x;
    for (int i = 1; i < 12; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      s    = s + term;
    end
    return $rtoi(real'(mid_val(OUT_W) - 1) * s + 0.5);
  endfunction

  logic [OUT_W-1:0] rom [QN+1];

  for (genvar j = 0; j <= QN; j++) begin : g_rom
    localparam logic [OUT_W-1:0] QV = OUT_W'(q_of(j));
    assign rom[j] = QV;
  end

  logic [1:0]        quad;
  logic [LUT_AW-3:0] m;
  logic [LUT_AW-2:0] idx;
  logic [OUT_W-1:0]  q;
  logic [OUT_W-1:0]  sine;

  assign quad = phase[LUT_AW-1 -: 2];
  assign m    = phase[LUT_AW-3:0];
  // Odd quadrants run the table backwards; m = 0 lands on the peak entry QN.
  assign idx  = quad[0] ? ((LUT_AW-1)'(QN) - {1'b0, m}) : {1'b0, m};
  assign q    = rom[idx];
  assign sine = quad[1] ? (MID - q) : (MID + q);

  // S2: registered waveform sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample <= MID;
    end else begin
      sample <= sel_alt ? alt : sine;
    end
  end

endmodule

// File: rtl/ddfs_mc.sv
// Multi-channel DDFS: per-channel shadow/active config, phase accumulator,
// phase-offset stage (S1) and waveform stage (S2) with a coherent commit.
module ddfs_mc
  import ddfs_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int ACC_W  = 23,
  parameter int OUT_W  = 8,
  parameter int LUT_AW = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [ch_width(NCH)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]         cfg_fcw,
  input  logic [ACC_W-1:0]         cfg_poff,
  input  logic [1:0]               cfg_mode,
  input  logic                     cfg_commit,
  input  logic                     sync,
  input  logic                     enable,
  output logic [NCH*OUT_W-1:0]     outp,
  output logic [NCH-1:0]           wrap
);

  localparam int CH_W = ch_width(NCH);
  // Only the top phase bits feed any waveform, so only those are pipelined.
  localparam int PW   = (LUT_AW > OUT_W + 1) ? LUT_AW : OUT_W + 1;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [ACC_W-1:0] sh_fcw, sh_poff, act_fcw, act_poff, acc;
    mode_t            sh_mode, act_mode;
    logic             wr_acc;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] phase;
    logic             hit;
    logic [PW-1:0]    ph_p1;
    mode_t            mode_p1;
    logic             wrap_p1;
    logic             wrap_p2;
    logic [OUT_W-1:0] t, r, alt;
    logic             sel_alt;

    assign hit   = cfg_we && (cfg_ch == CH_W'(c));
    assign sum   = {1'b0, acc} + {1'b0, act_fcw};
    assign phase = acc + act_poff;

    // Commit takes the shadow, or the same-cycle write when it targets this channel.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sh_fcw   <= '0;
        sh_poff  <= '0;
        sh_mode  <= SINE;
        act_fcw  <= '0;
        act_poff <= '0;
        act_mode <= SINE;
      end else begin
        if (hit) begin
          sh_fcw  <= cfg_fcw;
          sh_poff <= cfg_poff;
          sh_mode <= mode_t'(cfg_mode);
        end
        if (cfg_commit) begin
          act_fcw  <= hit ? cfg_fcw : sh_fcw;
          act_poff <= hit ? cfg_poff : sh_poff;
          act_mode <= hit ? mode_t'(cfg_mode) : sh_mode;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc    <= '0;
        wr_acc <= 1'b0;
      end else if (sync) begin
        acc    <= '0;
        wr_acc <= 1'b0;
      end else if (enable) begin
        acc    <= sum[ACC_W-1:0];
        wr_acc <= sum[ACC_W];
      end else begin
        wr_acc <= 1'b0;
      end
    end

    // S1: offset phase, mode and wrap flag
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ph_p1   <= '0;
        mode_p1 <= SINE;
        wrap_p1 <= 1'b0;
      end else begin
        ph_p1   <= phase[ACC_W-1 -: PW];
        mode_p1 <= act_mode;
        wrap_p1 <= wr_acc;
      end
    end

    assign t = ph_p1[PW-1 -: OUT_W];
    assign r = ph_p1[PW-2 -: OUT_W];

    always_comb begin
      alt     = '0;
      sel_alt = 1'b1;
      unique case (mode_p1)
        SQUARE:  alt = ph_p1[PW-1] ? '0 : '1;
        SAW:     alt = t;
        TRI:     alt = ph_p1[PW-1] ? ~r : r;
        default: sel_alt = 1'b0;
      endcase
    end

    ddfs_sine_lut #(
      .OUT_W  (OUT_W),
      .LUT_AW (LUT_AW)
    ) u_lut (
      .clk     (clk),
      .rst_n   (rst_n),
      .phase   (ph_p1[PW-1 -: LUT_AW]),
      .alt     (alt),
      .sel_alt (sel_alt),
      .sample  (outp[c*OUT_W +: OUT_W])
    );

    // S2: wrap flag aligned with the sample
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wrap_p2 <= 1'b0;
      end else begin
        wrap_p2 <= wrap_p1;
      end
    end

    assign wrap[c] = wrap_p2;
  end

endmodule
